// File: rtl/cpu_pio_gpio_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : cpu_pio_gpio_if
//  Description : Avalon-MM slave bus bundle for the PIO/GPIO register block.
//                The CPU side uses the master modport and the PIO the slave one.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cpu_pio_gpio_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface
`default_nettype wire

// File: rtl/cpu_pio_gpio.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : cpu_pio_gpio
//  Description : Parametrised PIO slave with per-bit direction, atomic
//                set/clear, per-bit blink from a shared prescaler and
//                synchronised edge capture with a maskable level interrupt.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_pio_gpio #(
    parameter int                 WIDTH       = 4,
    parameter logic [WIDTH-1:0]   RESET_VALUE = '0,
    parameter logic [WIDTH-1:0]   DIR_RESET   = '1,
    parameter int                 EDGE_TYPE   = 0,
    parameter int                 PRESCALE_W  = 24
) (
    input  wire logic              clk,
    input  wire logic              reset_n,
    cpu_pio_gpio_if.slave          bus,
    input  wire logic [WIDTH-1:0]  in_port,
    output logic      [WIDTH-1:0]  out_port,
    output logic      [WIDTH-1:0]  oe_port,
    output logic                   irq
);

    localparam logic [2:0] c_addr_data     = 3'd0;
    localparam logic [2:0] c_addr_dir      = 3'd1;
    localparam logic [2:0] c_addr_irq_mask = 3'd2;
    localparam logic [2:0] c_addr_edge_cap = 3'd3;
    localparam logic [2:0] c_addr_outset   = 3'd4;
    localparam logic [2:0] c_addr_outclr   = 3'd5;
    localparam logic [2:0] c_addr_blink_en = 3'd6;
    localparam logic [2:0] c_addr_period   = 3'd7;

    localparam logic [PRESCALE_W-1:0] c_cnt_one = (PRESCALE_W)'(1);

    logic [WIDTH-1:0]      r_data_out;
    logic [WIDTH-1:0]      r_dir;
    logic [WIDTH-1:0]      r_irq_mask;
    logic [WIDTH-1:0]      r_edge_cap;
    logic [WIDTH-1:0]      r_blink_en;
    logic [PRESCALE_W-1:0] r_period;
    logic [PRESCALE_W-1:0] r_cnt;
    logic                  r_phase;
    logic [WIDTH-1:0]      r_s1;
    logic [WIDTH-1:0]      r_in_sync;
    logic [WIDTH-1:0]      r_in_prev;

    logic                  w_wr;
    logic [WIDTH-1:0]      w_wdata;
    logic [WIDTH-1:0]      w_cap_clr;
    logic [WIDTH-1:0]      w_edge;
    logic [31:0]           w_rdata;
    logic                  w_unused_wdata;

    assign w_wr    = bus.chipselect & ~bus.write_n;
    assign w_wdata = bus.writedata[WIDTH-1:0];
    // Bits above WIDTH / PRESCALE_W are deliberately ignored.
    assign w_unused_wdata = ^bus.writedata;

    assign w_cap_clr = (w_wr && bus.address == c_addr_edge_cap) ? w_wdata : '0;

    // Two-flop synchroniser plus one history flop for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1      <= '0;
            r_in_sync <= '0;
            r_in_prev <= '0;
        end else begin
            r_s1      <= in_port;
            r_in_sync <= r_s1;
            r_in_prev <= r_in_sync;
        end
    end

    // Edge selection is fixed at elaboration time by EDGE_TYPE.
    always_comb begin
        w_edge = '0;
        case (EDGE_TYPE)
            0:       w_edge = r_in_sync & ~r_in_prev;
            1:       w_edge = ~r_in_sync & r_in_prev;
            default: w_edge = r_in_sync ^ r_in_prev;
        endcase
    end

    // Software-visible control registers, including atomic OUTSET/OUTCLR.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data_out <= RESET_VALUE;
            r_dir      <= DIR_RESET;
            r_irq_mask <= '0;
            r_blink_en <= '0;
            r_period   <= '0;
        end else if (w_wr) begin
            case (bus.address)
                c_addr_data:     r_data_out <= w_wdata;
                c_addr_dir:      r_dir      <= w_wdata;
                c_addr_irq_mask: r_irq_mask <= w_wdata;
                c_addr_outset:   r_data_out <= r_data_out | w_wdata;
                c_addr_outclr:   r_data_out <= r_data_out & ~w_wdata;
                c_addr_blink_en: r_blink_en <= w_wdata;
                c_addr_period:   r_period   <= bus.writedata[PRESCALE_W-1:0];
                default:         ;
            endcase
        end
    end

    // Edge capture: a new edge beats a simultaneous write-1-to-clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_edge_cap <= '0;
        end else begin
            r_edge_cap <= (r_edge_cap & ~w_cap_clr) | w_edge;
        end
    end

    // Blink prescaler: half-period of P+1 cycles, restarted by any period write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            r_phase <= 1'b1;
        end else if (w_wr && bus.address == c_addr_period) begin
            r_cnt   <= '0;
            r_phase <= 1'b1;
        end else if (r_period == '0) begin
            r_cnt   <= '0;
            r_phase <= 1'b1;
        end else if (r_cnt == r_period) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
        end else begin
            r_cnt   <= r_cnt + c_cnt_one;
        end
    end

    // Zero-wait-state read mux, zero-extended to the bus width.
    always_comb begin
        w_rdata = '0;
        case (bus.address)
            c_addr_data:     w_rdata[WIDTH-1:0] = (r_data_out & r_dir) | (r_in_sync & ~r_dir);
            c_addr_dir:      w_rdata[WIDTH-1:0] = r_dir;
            c_addr_irq_mask: w_rdata[WIDTH-1:0] = r_irq_mask;
            c_addr_edge_cap: w_rdata[WIDTH-1:0] = r_edge_cap;
            c_addr_blink_en: w_rdata[WIDTH-1:0] = r_blink_en;
            c_addr_period:   w_rdata[PRESCALE_W-1:0] = r_period;
            default:         w_rdata = '0;
        endcase
    end

    assign bus.readdata = w_rdata;

    // Blinking bits are gated by the phase; a bit whose data is 0 stays low.
    assign out_port = r_data_out & ~(r_blink_en & {WIDTH{~r_phase}});
    assign oe_port  = r_dir;
    assign irq      = |(r_edge_cap & r_irq_mask);

endmodule
`default_nettype wire

// File: tb/tb_cpu_pio_gpio.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_pio_gpio
//  Description : Self-checking bench for cpu_pio_gpio (WIDTH=4,
//                RESET_VALUE=4'h5) with directed scenarios and a randomized
//                run against a behavioural register-map model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_pio_gpio;

    logic       clk;
    logic       reset_n;
    logic [3:0] in_port;
    logic [3:0] out_port;
    logic [3:0] oe_port;
    logic       irq;

    int n_cmp = 0;
    int n_bad = 0;

    cpu_pio_gpio_if bus_if();

    cpu_pio_gpio #(
        .WIDTH       (4),
        .RESET_VALUE (4'h5),
        .DIR_RESET   (4'hF),
        .EDGE_TYPE   (0),
        .PRESCALE_W  (24)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus_if.slave),
        .in_port  (in_port),
        .out_port (out_port),
        .oe_port  (oe_port),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: register contents, a sample history of in_port and
    // the number of edges since the blink timebase was last restarted.
    logic [3:0]  m_data, m_dir, m_mask, m_cap, m_ben;
    logic [23:0] m_period;
    int          m_n;
    logic [3:0]  m_hist[$];

    function automatic void model_reset();
        m_data = 4'h5; m_dir = 4'hF; m_mask = 4'h0; m_cap = 4'h0;
        m_ben = 4'h0; m_period = 24'h0; m_n = 0;
        m_hist = '{4'h0, 4'h0, 4'h0};
    endfunction

    function automatic logic exp_phase();
        if (m_period == 24'h0) return 1'b1;
        return ((m_n / (int'(m_period) + 1)) % 2) == 0;
    endfunction

    function automatic logic [3:0] exp_out();
        return exp_phase() ? m_data : (m_data & ~m_ben);
    endfunction

    function automatic logic [31:0] exp_read(input logic [2:0] a);
        case (a)
            3'd0: return {28'h0, (m_data & m_dir) | (m_hist[1] & ~m_dir)};
            3'd1: return {28'h0, m_dir};
            3'd2: return {28'h0, m_mask};
            3'd3: return {28'h0, m_cap};
            3'd6: return {28'h0, m_ben};
            3'd7: return {8'h0, m_period};
            default: return 32'h0;
        endcase
    endfunction

    // One bus cycle: drive, take the edge, advance the model, then present a
    // read address and return 1ns after the falling edge.
    task automatic cycle(input logic cs, input logic wn, input logic [2:0] a,
                         input logic [31:0] d, input logic [3:0] ip,
                         input logic [2:0] raddr);
        logic       wr;
        logic [3:0] rise;
        bus_if.chipselect = cs; bus_if.write_n = wn;
        bus_if.address = a; bus_if.writedata = d; in_port = ip;
        @(posedge clk);
        wr   = cs & ~wn;
        rise = m_hist[1] & ~m_hist[2];
        m_cap = (m_cap & ~((wr && a == 3'd3) ? d[3:0] : 4'h0)) | rise;
        m_hist.push_front(ip);
        void'(m_hist.pop_back());
        m_n++;
        if (wr) begin
            case (a)
                3'd0: m_data = d[3:0];
                3'd1: m_dir  = d[3:0];
                3'd2: m_mask = d[3:0];
                3'd4: m_data = m_data | d[3:0];
                3'd5: m_data = m_data & ~d[3:0];
                3'd6: m_ben  = d[3:0];
                3'd7: begin m_period = d[23:0]; m_n = 0; end
                default: ;
            endcase
        end
        @(negedge clk);
        bus_if.chipselect = 1'b0; bus_if.write_n = 1'b1;
        bus_if.address = raddr;
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d,
                      input logic [3:0] ip, input logic [2:0] raddr);
        cycle(1'b1, 1'b0, a, d, ip, raddr);
    endtask

    task automatic idle(input logic [3:0] ip, input logic [2:0] raddr);
        cycle(1'b0, 1'b1, 3'd0, 32'h0, ip, raddr);
    endtask

    task automatic test_reset();
        logic [2:0] ra[4];
        ra = '{3'd2, 3'd3, 3'd6, 3'd7};
        reset_n = 1'b0; in_port = 4'h0;
        bus_if.chipselect = 1'b0; bus_if.write_n = 1'b1;
        bus_if.address = 3'd0; bus_if.writedata = 32'h0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        #1;
        n_cmp++; if (out_port !== 4'h5) begin n_bad++; $display("FAIL reset_out: got %h want 5", out_port); end
        n_cmp++; if (oe_port !== 4'hF) begin n_bad++; $display("FAIL reset_oe: got %h want f", oe_port); end
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq: got %b want 0", irq); end
        foreach (ra[i]) begin
            idle(4'h0, ra[i]);
            n_cmp++;
            if (bus_if.readdata !== 32'h0) begin
                n_bad++; $display("FAIL reset_read a=%0d: got %h want 0", ra[i], bus_if.readdata);
            end
        end
    endtask

    task automatic test_set_clr();
        wr(3'd0, 32'hFFFF_FFFA, 4'h0, 3'd0);
        n_cmp++; if (out_port !== 4'hA) begin n_bad++; $display("FAIL data_write: got %h want a", out_port); end
        wr(3'd4, 32'h1, 4'h0, 3'd4);
        n_cmp++; if (out_port !== 4'hB) begin n_bad++; $display("FAIL outset: got %h want b", out_port); end
        n_cmp++; if (bus_if.readdata !== 32'h0) begin n_bad++; $display("FAIL outset_read: got %h want 0", bus_if.readdata); end
        wr(3'd5, 32'h8, 4'h0, 3'd5);
        n_cmp++; if (out_port !== 4'h3) begin n_bad++; $display("FAIL outclr: got %h want 3", out_port); end
        n_cmp++; if (bus_if.readdata !== 32'h0) begin n_bad++; $display("FAIL outclr_read: got %h want 0", bus_if.readdata); end
    endtask

    task automatic test_input_edge();
        wr(3'd1, 32'h0, 4'h0, 3'd0);
        wr(3'd2, 32'h2, 4'h0, 3'd0);
        idle(4'h2, 3'd0);
        n_cmp++; if (bus_if.readdata !== 32'h0) begin n_bad++; $display("FAIL sync_1edge: got %h want 0", bus_if.readdata); end
        idle(4'h2, 3'd0);
        n_cmp++; if (bus_if.readdata !== 32'h2) begin n_bad++; $display("FAIL sync_2edge: got %h want 2", bus_if.readdata); end
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_early: got %b want 0", irq); end
        idle(4'h2, 3'd3);
        n_cmp++; if (bus_if.readdata !== 32'h2) begin n_bad++; $display("FAIL edge_cap: got %h want 2", bus_if.readdata); end
        n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_set: got %b want 1", irq); end
        wr(3'd3, 32'h2, 4'h2, 3'd3);
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_clear: got %b want 0", irq); end
        n_cmp++; if (bus_if.readdata !== 32'h0) begin n_bad++; $display("FAIL cap_clear: got %h want 0", bus_if.readdata); end
    endtask

    task automatic test_collision();
        idle(4'h3, 3'd3);
        idle(4'h3, 3'd3);
        wr(3'd3, 32'h1, 4'h3, 3'd3);
        n_cmp++; if (bus_if.readdata !== 32'h1) begin n_bad++; $display("FAIL set_beats_clear: got %h want 1", bus_if.readdata); end
        wr(3'd3, 32'h1, 4'h3, 3'd3);
        n_cmp++; if (bus_if.readdata !== 32'h0) begin n_bad++; $display("FAIL plain_clear: got %h want 0", bus_if.readdata); end
    endtask

    task automatic test_blink();
        wr(3'd1, 32'hF, 4'h3, 3'd0);
        wr(3'd0, 32'h1, 4'h3, 3'd0);
        wr(3'd6, 32'h1, 4'h3, 3'd0);
        wr(3'd7, 32'h3, 4'h3, 3'd7);
        n_cmp++; if (bus_if.readdata !== 32'h3) begin n_bad++; $display("FAIL period_read: got %h want 3", bus_if.readdata); end
        n_cmp++; if (out_port[0] !== 1'b1) begin n_bad++; $display("FAIL blink_k0: got %b want 1", out_port[0]); end
        for (int k = 1; k < 16; k++) begin
            idle(4'h3, 3'd0);
            n_cmp++;
            if (out_port[0] !== (((k / 4) % 2) == 0)) begin
                n_bad++; $display("FAIL blink_k%0d: got %b want %b", k, out_port[0], ((k / 4) % 2) == 0);
            end
        end
        wr(3'd7, 32'h0, 4'h3, 3'd0);
        for (int k = 0; k < 6; k++) begin
            idle(4'h3, 3'd0);
            n_cmp++; if (out_port[0] !== 1'b1) begin n_bad++; $display("FAIL blink_p0_%0d: got %b want 1", k, out_port[0]); end
        end
        wr(3'd7, 32'h3, 4'h3, 3'd0);
        wr(3'd0, 32'h0, 4'h3, 3'd0);
        for (int k = 0; k < 8; k++) begin
            idle(4'h3, 3'd0);
            n_cmp++; if (out_port[0] !== 1'b0) begin n_bad++; $display("FAIL blink_d0_%0d: got %b want 0", k, out_port[0]); end
        end
    endtask

    task automatic test_async_reset();
        wr(3'd7, 32'h2, 4'h3, 3'd0);
        wr(3'd0, 32'h1, 4'h3, 3'd0);
        wr(3'd2, 32'h4, 4'h4, 3'd0);
        idle(4'h4, 3'd0);
        idle(4'h4, 3'd3);
        n_cmp++; if (bus_if.readdata !== 32'h4) begin n_bad++; $display("FAIL pre_reset_cap: got %h want 4", bus_if.readdata); end
        n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL pre_reset_irq: got %b want 1", irq); end
        idle(4'h4, 3'd3);
        #1 reset_n = 1'b0;
        #1;
        n_cmp++; if (out_port !== 4'h5) begin n_bad++; $display("FAIL async_out: got %h want 5", out_port); end
        n_cmp++; if (oe_port !== 4'hF) begin n_bad++; $display("FAIL async_oe: got %h want f", oe_port); end
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL async_irq: got %b want 0", irq); end
        n_cmp++; if (bus_if.readdata !== 32'h0) begin n_bad++; $display("FAIL async_cap: got %h want 0", bus_if.readdata); end
        bus_if.address = 3'd7;
        #1;
        n_cmp++; if (bus_if.readdata !== 32'h0) begin n_bad++; $display("FAIL async_period: got %h want 0", bus_if.readdata); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        // Input held high through reset gives one capture three edges later.
        idle(4'h4, 3'd3);
        idle(4'h4, 3'd3);
        n_cmp++; if (bus_if.readdata !== 32'h0) begin n_bad++; $display("FAIL post_reset_2edge: got %h want 0", bus_if.readdata); end
        idle(4'h4, 3'd3);
        n_cmp++; if (bus_if.readdata !== 32'h4) begin n_bad++; $display("FAIL post_reset_3edge: got %h want 4", bus_if.readdata); end
    endtask

    task automatic test_random();
        logic        c, w;
        logic [2:0]  a, ra;
        logic [31:0] d;
        logic [3:0]  ip;
        ip = 4'h4;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 3) == 0) ip = 4'($urandom);
            a = 3'($urandom);
            d = $urandom;
            if (a == 3'd7) d = (d & 32'hFF00_0000) | 32'($urandom_range(0, 5));
            c  = ($urandom_range(0, 3) != 0);
            w  = ($urandom_range(0, 1) == 0);
            ra = 3'($urandom);
            cycle(c, w, a, d, ip, ra);
            n_cmp++; if (out_port !== exp_out()) begin n_bad++; $display("FAIL rand_out i=%0d: got %h want %h", i, out_port, exp_out()); end
            n_cmp++; if (oe_port !== m_dir) begin n_bad++; $display("FAIL rand_oe i=%0d: got %h want %h", i, oe_port, m_dir); end
            n_cmp++; if (irq !== (|(m_cap & m_mask))) begin n_bad++; $display("FAIL rand_irq i=%0d: got %b want %b", i, irq, |(m_cap & m_mask)); end
            n_cmp++; if (bus_if.readdata !== exp_read(ra)) begin n_bad++; $display("FAIL rand_read i=%0d a=%0d: got %h want %h", i, ra, bus_if.readdata, exp_read(ra)); end
        end
    endtask

    initial begin
        test_reset();
        test_set_clr();
        test_input_edge();
        test_collision();
        test_blink();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
